// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer owning the PC, retire counter and trap.
// Optional single-step halt after each retire: define CORE_SEQ_SINGLE_STEP_EN.
module core_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h8000_0000,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  output logic        dmem_req,
  input  logic        dmem_ack,
  input  logic        is_mem,
  input  logic        is_system,
  input  logic        trap_cond,
  input  logic [31:0] pc_next,
  output logic [31:0] pc,
  output logic        ins_en,
  output logic        dec_en,
  output logic        exe_en,
  output logic        wb_en,
  output logic [2:0]  state,
  output logic        trap,
`ifdef CORE_SEQ_SINGLE_STEP_EN
  input  logic        step_req,
  output logic        halted,
`endif
  output logic [1:0]  trap_cause,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StDecode    = 3'd1,
    StExecute   = 3'd2,
    StMem       = 3'd3,
    StWriteback = 3'd4,
    StTrap      = 3'd5,
    StHalt      = 3'd6
  } state_e;

  localparam logic [1:0] CauseNone     = 2'b00;
  localparam logic [1:0] CauseSystem   = 2'b01;
  localparam logic [1:0] CauseTimeout  = 2'b10;
  localparam logic [1:0] CauseMisalign = 2'b11;

  // Counter value on the last permitted wait cycle; an ack on that cycle still wins.
  localparam logic [15:0] WaitLast = 16'(MEM_TIMEOUT - 32'd1);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instret_q;
  logic [15:0] wait_q;
  logic        trap_q;
  logic [1:0]  cause_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      instret_q <= '0;
      wait_q    <= '0;
      trap_q    <= 1'b0;
      cause_q   <= CauseNone;
    end else begin
      case (state_q)
        StFetch: begin
          if (imem_ack) begin
            state_q <= StDecode;
            wait_q  <= '0;
          end else begin
            wait_q <= wait_q + 16'd1;
            if (wait_q == WaitLast) begin
              state_q <= StTrap;
              trap_q  <= 1'b1;
              cause_q <= CauseTimeout;
            end
          end
        end
        StDecode: begin
          if (is_system && trap_cond) begin
            state_q <= StTrap;
            trap_q  <= 1'b1;
            cause_q <= CauseSystem;
          end else begin
            state_q <= StExecute;
          end
        end
        StExecute: begin
          state_q <= is_mem ? StMem : StWriteback;
        end
        StMem: begin
          if (dmem_ack) begin
            state_q <= StWriteback;
            wait_q  <= '0;
          end else begin
            wait_q <= wait_q + 16'd1;
            if (wait_q == WaitLast) begin
              state_q <= StTrap;
              trap_q  <= 1'b1;
              cause_q <= CauseTimeout;
            end
          end
        end
        StWriteback: begin
          // A misaligned target traps before any architectural update.
          if (pc_next[1:0] != 2'b00) begin
            state_q <= StTrap;
            trap_q  <= 1'b1;
            cause_q <= CauseMisalign;
          end else begin
            pc_q      <= pc_next;
            instret_q <= instret_q + 32'd1;
`ifdef CORE_SEQ_SINGLE_STEP_EN
            state_q   <= StHalt;
`else
            state_q   <= StFetch;
`endif
          end
        end
        StHalt: begin
`ifdef CORE_SEQ_SINGLE_STEP_EN
          if (step_req) begin
            state_q <= StFetch;
          end
`else
          state_q <= StFetch;
`endif
        end
        StTrap: begin
          state_q <= StTrap;
        end
        default: begin
          state_q <= StFetch;
        end
      endcase
    end
  end

  // Strobes are state decodes, gated by resetn so they are all low while reset is held.
  assign imem_req   = resetn && (state_q == StFetch);
  assign dmem_req   = resetn && (state_q == StMem);
  assign ins_en     = imem_req && imem_ack;
  assign dec_en     = resetn && (state_q == StDecode);
  assign exe_en     = resetn && (state_q == StExecute);
  assign wb_en      = resetn && (state_q == StWriteback);
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign state      = state_q;
  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign instret    = instret_q;
`ifdef CORE_SEQ_SINGLE_STEP_EN
  assign halted     = resetn && (state_q == StHalt);
`endif

  req_exclusive: assert property (@(posedge clk) disable iff (!resetn) !(imem_req && dmem_req));
  trap_sticky: assert property (@(posedge clk) disable iff (!resetn) trap |=> trap);

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized scoreboard bench for core_sequencer: a per-instruction model schedules the inputs and
// queues the expected retire/trap events; a negedge monitor pops and compares them.
module tb_core_sequencer;

  localparam int unsigned   T   = 6;
  localparam logic [31:0]   RPC = 32'h8000_0000;

  logic        clk;
  logic        resetn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        dmem_req;
  logic        dmem_ack;
  logic        is_mem;
  logic        is_system;
  logic        trap_cond;
  logic [31:0] pc_next;
  logic [31:0] pc;
  logic        ins_en;
  logic        dec_en;
  logic        exe_en;
  logic        wb_en;
  logic [2:0]  state;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] instret;

  core_sequencer #(
    .RESET_PC    (RPC),
    .MEM_TIMEOUT (T)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .dmem_req   (dmem_req),
    .dmem_ack   (dmem_ack),
    .is_mem     (is_mem),
    .is_system  (is_system),
    .trap_cond  (trap_cond),
    .pc_next    (pc_next),
    .pc         (pc),
    .ins_en     (ins_en),
    .dec_en     (dec_en),
    .exe_en     (exe_en),
    .wb_en      (wb_en),
    .state      (state),
    .trap       (trap),
    .trap_cause (trap_cause),
    .instret    (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_trap;
    int unsigned cyc;
    logic [31:0] pc;
    logic [31:0] instret;
    logic [1:0]  cause;
    int unsigned icyc;
    int unsigned dcyc;
  } exp_t;

  exp_t        sbq[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  logic [31:0] m_pc;
  logic [31:0] m_instret;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: invariants every cycle, scoreboard pop on each retire strobe or trap onset.
  bit          trap_seen;
  int unsigned icnt;
  int unsigned dcnt;
  exp_t        mon_e;
  initial forever begin
    @(negedge clk);
    if (!resetn) begin
      trap_seen = 1'b0;
      icnt      = 0;
      dcnt      = 0;
    end else begin
      if (imem_req) icnt++;
      if (dmem_req) dcnt++;
      chk("imem_addr_eq_pc", imem_addr, pc);
      chk("req_exclusive", 32'(imem_req & dmem_req), 32'd0);
      if (trap) begin
        chk("trap_state", 32'(state), 32'd5);
        chk("trap_quiet", 32'({imem_req, dmem_req, ins_en, dec_en, exe_en, wb_en}), 32'd0);
      end
      if (wb_en || (trap && !trap_seen)) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got wb_en=%0b trap=%0b, want no event (cycle %0d)",
                   wb_en, trap, cyc);
        end else begin
          mon_e = sbq.pop_front();
          chk("ev_kind", 32'(trap), 32'(mon_e.is_trap));
          chk("ev_cycle", cyc, mon_e.cyc);
          chk("ev_pc", pc, mon_e.pc);
          chk("ev_instret", instret, mon_e.instret);
          if (mon_e.is_trap) begin
            chk("ev_cause", 32'(trap_cause), 32'(mon_e.cause));
          end else begin
            chk("fetch_req_cycles", icnt, mon_e.icyc);
            chk("mem_req_cycles", dcnt, mon_e.dcyc);
          end
        end
        if (wb_en) begin
          icnt = 0;
          dcnt = 0;
        end
        if (trap) trap_seen = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs outside their valid phase are randomized; the DUT must ignore them.
  task automatic noise();
    imem_ack  = 1'($urandom());
    dmem_ack  = 1'($urandom());
    is_mem    = 1'($urandom());
    is_system = 1'($urandom());
    trap_cond = 1'($urandom());
    pc_next   = $urandom();
  endtask

  task automatic push_ev(input bit is_trap, input logic [1:0] cause, input int unsigned ic,
                         input int unsigned dc);
    exp_t e;
    e.is_trap = is_trap;
    e.cyc     = cyc;
    e.pc      = m_pc;
    e.instret = m_instret;
    e.cause   = cause;
    e.icyc    = ic;
    e.dcyc    = dc;
    sbq.push_back(e);
  endtask

  task automatic trap_tail(input logic [1:0] cause);
    push_ev(1'b1, cause, 0, 0);
    for (int i = 0; i < 3; i++) begin
      noise();
      tick();
    end
  endtask

  // One instruction: fd/md are ack wait cycles; a wait of T or more times out.
  task automatic run_instr(input int unsigned fd, input bit sys, input bit tc, input bit mem,
                           input int unsigned md, input bit misal, input bit seq,
                           output bit trapped);
    logic [31:0] pn;
    trapped = 1'b0;
    for (int unsigned i = 0; i < fd && i < T; i++) begin
      noise();
      imem_ack = 1'b0;
      tick();
    end
    if (fd >= T) begin
      trap_tail(2'b10);
      trapped = 1'b1;
      return;
    end
    noise();
    imem_ack = 1'b1;
    tick();
    noise();
    is_system = sys;
    trap_cond = tc;
    tick();
    if (sys && tc) begin
      trap_tail(2'b01);
      trapped = 1'b1;
      return;
    end
    noise();
    is_mem = mem;
    tick();
    if (mem) begin
      for (int unsigned i = 0; i < md && i < T; i++) begin
        noise();
        dmem_ack = 1'b0;
        tick();
      end
      if (md >= T) begin
        trap_tail(2'b10);
        trapped = 1'b1;
        return;
      end
      noise();
      dmem_ack = 1'b1;
      tick();
    end
    noise();
    pn = seq ? m_pc + 32'd4 : ($urandom() & 32'hFFFF_FFFC);
    if (misal) pn = pn | 32'($urandom_range(1, 3));
    pc_next = pn;
    push_ev(1'b0, 2'b00, fd + 1, mem ? md + 1 : 0);
    tick();
    if (misal) begin
      trap_tail(2'b11);
      trapped = 1'b1;
      return;
    end
    m_pc      = pn;
    m_instret = m_instret + 32'd1;
  endtask

  task automatic do_reset();
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    sbq.delete();
    resetn = 1'b0;
    noise();
    imem_ack = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pc", pc, RPC);
    chk("rst_instret", instret, 32'd0);
    chk("rst_trap", 32'({trap, trap_cause}), 32'd0);
    chk("rst_quiet", 32'({imem_req, dmem_req, ins_en, dec_en, exe_en, wb_en}), 32'd0);
    resetn    = 1'b1;
    m_pc      = RPC;
    m_instret = 32'd0;
  endtask

  // Drive into the second MEM wait cycle, then drop resetn mid-cycle.
  task automatic reset_mid_mem();
    noise();
    imem_ack = 1'b1;
    tick();
    noise();
    is_system = 1'b0;
    tick();
    noise();
    is_mem = 1'b1;
    tick();
    noise();
    dmem_ack = 1'b0;
    tick();
    noise();
    dmem_ack = 1'b0;
    #2;
    chk("mid_mem_req_before", 32'(dmem_req), 32'd1);
    resetn = 1'b0;
    #1;
    chk("mid_mem_req_dropped", 32'(dmem_req), 32'd0);
    chk("mid_mem_state", 32'(state), 32'd0);
    chk("mid_mem_pc", pc, RPC);
    chk("mid_mem_instret", instret, 32'd0);
  endtask

  bit          tr;
  int unsigned t0;
  int unsigned fd;
  int unsigned md;
  initial begin
    resetn    = 1'b0;
    imem_ack  = 1'b0;
    dmem_ack  = 1'b0;
    is_mem    = 1'b0;
    is_system = 1'b0;
    trap_cond = 1'b0;
    pc_next   = '0;
    m_pc      = RPC;
    m_instret = '0;
    do_reset();

    t0 = cyc;
    for (int i = 0; i < 3; i++) run_instr(0, 0, 0, 0, 0, 0, 1, tr);
    chk("seq_pc", pc, RPC + 32'd12);
    chk("seq_instret", instret, 32'd3);
    chk("seq_cycles", cyc - t0, 32'd12);

    run_instr(0, 0, 0, 1, 3, 0, 1, tr);
    run_instr(T - 1, 0, 0, 1, T - 1, 0, 1, tr);
    run_instr(0, 1, 0, 0, 0, 0, 1, tr);
    run_instr(0, 1, 1, 0, 0, 0, 1, tr);
    do_reset();
    run_instr(T, 0, 0, 0, 0, 0, 1, tr);
    do_reset();
    run_instr(0, 0, 0, 1, T, 0, 1, tr);
    do_reset();
    run_instr(0, 0, 0, 0, 0, 0, 1, tr);
    run_instr(0, 0, 0, 0, 0, 1, 1, tr);
    do_reset();
    run_instr(1, 0, 0, 0, 0, 0, 1, tr);
    run_instr(0, 0, 0, 1, 0, 0, 1, tr);
    reset_mid_mem();
    do_reset();

    for (int n = 0; n < 160; n++) begin
      fd = ($urandom_range(0, 19) == 0) ? T + $urandom_range(0, 2) : $urandom_range(0, T - 1);
      md = ($urandom_range(0, 19) == 0) ? T : $urandom_range(0, T - 1);
      run_instr(fd, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                1'($urandom()), md, $urandom_range(0, 24) == 0, 1'($urandom()), tr);
      if (tr) do_reset();
    end
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
